// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg: shared defaults, counter operations and the update-op selector
package branch_target_buffer_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_TAG_W   = 8;
    localparam int DEF_CNT_W   = 2;

    typedef enum logic [1:0] {
        CNT_OP_INC,
        CNT_OP_DEC,
        CNT_OP_MAX,
        CNT_OP_WEAK
    } cnt_op_e;

    // Jumps always force the counter to max; a fresh allocation starts weakly taken.
    function automatic cnt_op_e cnt_op_sel(input logic hit, input logic jump, input logic taken);
        return jump ? CNT_OP_MAX : !hit ? CNT_OP_WEAK : taken ? CNT_OP_INC : CNT_OP_DEC;
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// branch_target_buffer_sat_counter: combinational next state of a saturating direction counter
module branch_target_buffer_sat_counter
    import branch_target_buffer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  cnt_op_e          i_op,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(1) << (CNT_W - 1);

    // Increment and decrement clamp at the all-ones and zero ends.
    always_comb begin
        o_cnt = i_op == CNT_OP_MAX  ? '1 :
                i_op == CNT_OP_WEAK ? WEAK_T :
                i_op == CNT_OP_INC  ? (&i_cnt ? i_cnt : i_cnt + CNT_W'(1)) :
                                      (~|i_cnt ? i_cnt : i_cnt - CNT_W'(1));
    end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with tags, direction counters and mispredict statistics
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_if_pc,
    output logic              o_pred_taken,
    output logic [DATA_W-1:0] o_pred_target,
    input  logic              i_upd_valid,
    input  logic [DATA_W-1:0] i_upd_pc,
    input  logic [DATA_W-1:0] i_upd_target,
    input  logic              i_upd_taken,
    input  logic              i_upd_is_jump,
    input  logic              i_upd_mispredict,
    input  logic              i_inv_all,
    output logic [31:0]       o_mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_jump;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];
    logic [DATA_W-1:0]  r_target [ENTRIES];
    logic [31:0]        r_mispredict_cnt;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic             w_write;
    cnt_op_e          w_op;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_unused_pc;

    assign w_unused_pc = ^{i_if_pc, i_upd_pc};

    // Fetch-side lookup; pc[1:0] and bits above the tag take no part.
    always_comb begin
        w_idx         = i_if_pc[IDX_W+1:2];
        w_tag         = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
        w_hit         = r_valid[w_idx] && r_tag[w_idx] == w_tag;
        o_pred_taken  = w_hit && (r_jump[w_idx] || r_cnt[w_idx][CNT_W-1]);
        o_pred_target = o_pred_taken ? r_target[w_idx] : '0;
    end

    // Update-side decode: write on a hit, or allocate on a taken miss, unless invalidated.
    always_comb begin
        w_uidx  = i_upd_pc[IDX_W+1:2];
        w_utag  = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
        w_uhit  = r_valid[w_uidx] && r_tag[w_uidx] == w_utag;
        w_op    = cnt_op_sel(w_uhit, i_upd_is_jump, i_upd_taken);
        w_write = i_enable && i_upd_valid && !i_inv_all && (w_uhit || i_upd_taken);
    end

    branch_target_buffer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .i_op  (w_op),
        .i_cnt (r_cnt[w_uidx]),
        .o_cnt (w_cnt_next)
    );

    assign o_mispredict_cnt = r_mispredict_cnt;

    // Table and statistics state; invalidate wins over a same-cycle update.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_valid          <= '0;
            r_jump           <= '0;
            r_mispredict_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_cnt[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (i_enable) begin
            if (i_inv_all) begin
                r_valid <= '0;
            end else if (w_write) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_jump[w_uidx]   <= i_upd_is_jump;
                r_target[w_uidx] <= i_upd_target;
                r_cnt[w_uidx]    <= w_cnt_next;
            end
            if (i_upd_valid && i_upd_mispredict && !(&r_mispredict_cnt))
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed and randomized checks of the BTB against a table model
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] if_pc = '0;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [63:0] upd_pc = '0;
    logic [63:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        upd_is_jump = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        inv_all = 1'b0;
    logic [31:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;

    bit          m_valid [16];
    bit [7:0]    m_tag   [16];
    bit          m_jump  [16];
    int          m_cnt   [16];
    logic [63:0] m_tgt   [16];
    longint      m_mis;

    branch_target_buffer dut (
        .i_clk            (clk),
        .i_arst_n         (arst_n),
        .i_enable         (enable),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_upd_valid      (upd_valid),
        .i_upd_pc         (upd_pc),
        .i_upd_target     (upd_target),
        .i_upd_taken      (upd_taken),
        .i_upd_is_jump    (upd_is_jump),
        .i_upd_mispredict (upd_mispredict),
        .i_inv_all        (inv_all),
        .o_mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_jump[i]  = 0;
            m_cnt[i]   = 0;
            m_tgt[i]   = 0;
        end
        m_mis = 0;
    endfunction

    // Reference update: counter range 0..3, taken threshold 2, weak-taken start 2.
    function automatic void m_update();
        int  idx;
        bit  hit;
        if (!enable) return;
        if (upd_valid && upd_mispredict && m_mis < 64'hFFFF_FFFF) m_mis++;
        if (inv_all) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            return;
        end
        if (!upd_valid) return;
        idx = int'((upd_pc / 4) % 16);
        hit = m_valid[idx] && m_tag[idx] == 8'((upd_pc / 64) % 256);
        if (hit) begin
            m_tgt[idx]  = upd_target;
            m_jump[idx] = upd_is_jump;
            m_cnt[idx]  = upd_is_jump ? 3 : upd_taken ? (m_cnt[idx] == 3 ? 3 : m_cnt[idx] + 1)
                                                      : (m_cnt[idx] == 0 ? 0 : m_cnt[idx] - 1);
        end else if (upd_taken) begin
            m_valid[idx] = 1;
            m_tag[idx]   = 8'((upd_pc / 64) % 256);
            m_tgt[idx]   = upd_target;
            m_jump[idx]  = upd_is_jump;
            m_cnt[idx]   = upd_is_jump ? 3 : 2;
        end
    endfunction

    task automatic look(input string tag);
        int idx;
        bit t;
        idx = int'((if_pc / 4) % 16);
        t = m_valid[idx] && m_tag[idx] == 8'((if_pc / 64) % 256) && (m_jump[idx] || m_cnt[idx] >= 2);
        chk({tag, "_taken"}, 64'(pred_taken), 64'(t));
        chk({tag, "_target"}, pred_target, t ? m_tgt[idx] : 64'h0);
        chk({tag, "_miscnt"}, 64'(mispredict_cnt), 64'(m_mis));
    endtask

    task automatic step(input string tag);
        #1;
        look(tag);
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input bit tk, input bit jmp, input bit mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_is_jump    = jmp;
        upd_mispredict = mis;
    endtask

    task automatic idle();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        inv_all        = 1'b0;
    endtask

    initial begin
        m_reset();
        if_pc = 64'h40;
        #1;
        chk("t1_reset_taken", 64'(pred_taken), 64'h0);
        chk("t1_reset_target", pred_target, 64'h0);
        chk("t1_reset_miscnt", 64'(mispredict_cnt), 64'h0);
        #8 arst_n = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;

        upd(64'h40, 64'h80, 1, 0, 0);
        step("t2_upd");
        idle();
        #1;
        chk("t2_taken", 64'(pred_taken), 64'h1);
        chk("t2_target", pred_target, 64'h80);

        upd(64'h40, 64'h80, 0, 0, 0);
        step("t3_nt1");
        #1;
        chk("t3_nt1_taken", 64'(pred_taken), 64'h0);
        step("t3_nt2");
        upd(64'h40, 64'h80, 1, 0, 0);
        step("t3_tk");
        idle();
        #1;
        chk("t3_tk_taken", 64'(pred_taken), 64'h0);

        upd(64'h40, 64'h100, 1, 1, 0);
        step("t4_jump");
        idle();
        #1;
        chk("t4_jump_target", pred_target, 64'h100);
        upd(64'h140, 64'h200, 1, 0, 0);
        step("t4_repl");
        idle();
        step("t4_old");
        #1;
        chk("t4_old_miss", 64'(pred_taken), 64'h0);
        if_pc = 64'h143;
        #1;
        chk("t4_new_target", pred_target, 64'h200);

        upd(64'h500, 64'h0, 0, 0, 1);
        step("t5_m1");
        step("t5_m2");
        enable = 1'b0;
        upd(64'h140, 64'h0, 0, 0, 1);
        step("t5_dis");
        enable = 1'b1;
        upd(64'h500, 64'h0, 0, 0, 1);
        step("t5_m3");
        idle();
        #1;
        chk("t5_cnt3", 64'(mispredict_cnt), 64'd3);
        chk("t5_frozen_target", pred_target, 64'h200);
        force dut.r_mispredict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_mispredict_cnt;
        m_mis = 64'hFFFF_FFFE;
        upd(64'h500, 64'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t5_sat");
        idle();
        #1;
        chk("t5_saturated", 64'(mispredict_cnt), 64'hFFFF_FFFF);

        upd(64'h40, 64'h300, 1, 1, 0);
        step("t6_fill");
        inv_all = 1'b1;
        upd(64'h84, 64'h400, 1, 0, 0);
        step("t6_inv");
        idle();
        for (int i = 0; i < 4; i++) begin
            if_pc = (i == 0) ? 64'h84 : (i == 1) ? 64'h40 : (i == 2) ? 64'h143 : 64'h500;
            #1;
            chk("t6_inv_miss", 64'(pred_taken), 64'h0);
        end
        if_pc = 64'h84;
        upd(64'h84, 64'h400, 1, 1, 1);
        step("t6_alloc");
        idle();
        #1;
        chk("t6_alloc_taken", 64'(pred_taken), 64'h1);
        upd(64'h84, 64'h0, 0, 0, 1);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_arst_taken", 64'(pred_taken), 64'h0);
        chk("t6_arst_target", pred_target, 64'h0);
        chk("t6_arst_miscnt", 64'(mispredict_cnt), 64'h0);
        m_reset();
        idle();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        look("t6_post");

        for (int n = 0; n < 600; n++) begin
            enable         = $urandom_range(0, 9) != 0;
            upd_valid      = $urandom_range(0, 1) != 0;
            upd_pc         = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2)
                             | 64'($urandom_range(0, 3)) | ({32'($urandom), 32'h0} & {32'hFFFF_FFFF, 32'h0});
            upd_target     = {$urandom, $urandom};
            upd_taken      = $urandom_range(0, 2) != 0;
            upd_is_jump    = $urandom_range(0, 4) == 0;
            upd_mispredict = $urandom_range(0, 1) != 0;
            inv_all        = $urandom_range(0, 40) == 0;
            if_pc          = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2)
                             | 64'($urandom_range(0, 3)) | {32'($urandom), 32'h0};
            step("rnd");
        end
        idle();
        step("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
